// File: rtl/sram_pkg.sv
// Shared types and helpers for the parametrised flip-flop SRAM.
package sram_pkg;

   // Controller states: INIT zeroes the array word by word, IDLE serves user traffic.
   typedef enum logic {INIT, IDLE} state_t;

   // Widest word the byte-merge helper handles; callers zero-extend into it
   // and cast the result back down to their own data width.
   localparam int MERGE_W    = 256;
   localparam int MERGE_BE_W = MERGE_W / 8;

   // Byte-wise merge: bytes with be=1 come from new_word, the rest from old_word.
   function automatic logic [MERGE_W-1:0] merge(
      input logic [MERGE_W-1:0]    old_word,
      input logic [MERGE_W-1:0]    new_word,
      input logic [MERGE_BE_W-1:0] be
   );
      logic [MERGE_W-1:0] res;
      res = old_word;
      for (int i = 0; i < MERGE_BE_W; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/sram_init_ctrl.sv
// Clear sequencer: walks a pointer over every word after reset or on
// request, and flags the array as busy until the last word is zeroed.
module sram_init_ctrl
   import sram_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          init_req,
   output logic          busy,
   output logic          clr_en,
   output logic [AW-1:0] clr_addr
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] ptr;
   logic [AW-1:0] ptr_nxt;

   // State and clear-pointer registers; reset restarts the clear from word 0
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= INIT;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Next state: INIT advances one word per edge, IDLE waits for a re-clear request
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         INIT: begin
            if (ptr == LAST) begin
               state_nxt = IDLE;
               ptr_nxt   = '0;
            end else begin
               ptr_nxt = ptr + 1'b1;
            end
         end
         IDLE: begin
            if (init_req) begin
               state_nxt = INIT;
               ptr_nxt   = '0;
            end
         end
      endcase
   end

   // Outputs decode only the registered state, so nothing here depends on inputs
   always_comb begin
      busy     = (state == INIT);
      clr_en   = (state == INIT);
      clr_addr = ptr;
   end

endmodule

// File: rtl/sram_dff_dp.sv
// One-write / one-read flip-flop SRAM with byte enables, a registered read
// port with valid strobe, write-first bypass and a hardware clear sequencer.
module sram_dff_dp
   import sram_pkg::*;
#(
   parameter int DW    = 32,
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [DW-1:0]   wd,
   input  logic [DW/8-1:0] wbe,
   input  logic            re,
   input  logic [AW-1:0]   raddr,
   output logic [DW-1:0]   rd,
   output logic            rvalid,
   input  logic            init_req,
   output logic            busy
);

   // Depth widened by one bit so non-power-of-two range checks cannot wrap.
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   // Storage has no reset; the clear sequencer zeroes it instead.
   logic [DW-1:0] mem [DEPTH];

   logic          clr_en;
   logic [AW-1:0] clr_addr;
   logic          accept;
   logic          wr_en;
   logic          wr_hit;
   logic          rd_in_range;
   logic [DW-1:0] wr_word;

   sram_init_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_init_ctrl (
      .clk      (clk),
      .resetn   (resetn),
      .init_req (init_req),
      .busy     (busy),
      .clr_en   (clr_en),
      .clr_addr (clr_addr)
   );

   // User traffic is only honoured in IDLE and never on the edge that starts a re-clear.
   assign accept      = ~busy & ~init_req;
   assign wr_en       = accept & we & ({1'b0, waddr} < DEPTH_W);
   assign rd_in_range = ({1'b0, raddr} < DEPTH_W);
   assign wr_hit      = wr_en & (waddr == raddr);
   assign wr_word     = DW'(merge(MERGE_W'(mem[waddr]), MERGE_W'(wd), MERGE_BE_W'(wbe)));

   // Array update: the clear sequencer wins over any user write
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_addr] <= '0;
      end else if (wr_en) begin
         mem[waddr] <= wr_word;
      end
   end

   // Read register: write-first bypass on address match, zero for out-of-range reads
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd     <= '0;
         rvalid <= 1'b0;
      end else if (accept && re) begin
         rvalid <= 1'b1;
         if (!rd_in_range) begin
            rd <= '0;
         end else if (wr_hit) begin
            rd <= wr_word;
         end else begin
            rd <= mem[raddr];
         end
      end else begin
         rvalid <= 1'b0;
      end
   end

endmodule

// File: doc/sram_dff_dp.md
# sram_dff_dp

Parametrised dual-port (one write, one read) flip-flop SRAM. It succeeds the fixed 8 x 32 D-FF memory with configurable width and depth, byte write enables, and a registered read with a valid strobe. It also adds a hardware clear sequencer that zeroes the array after reset or on request, because the storage flops themselves are not reset. It sits in the same datapath slot as the fixed SRAM: a small register-file memory between a producer (write port) and a consumer (read port).

## Interface
Parameters:
- DW, 32, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; must be at least 2; need not be a power of 2.
- AW, $clog2(DEPTH), address width (derived; do not override).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset; asynchronous, active-low.
- we  in  1  write request.
- waddr  in  AW  write address.
- wd  in  DW  write data.
- wbe  in  DW/8  byte enables; bit i gates wd[8i+7:8i].
- re  in  1  read request.
- raddr  in  AW  read address.
- rd  out  DW  registered read data.
- rvalid  out  1  one-cycle strobe; high when rd holds fresh data.
- init_req  in  1  request to re-clear the whole array.
- busy  out  1  high while clearing; all requests are ignored while high.

## Operation
- **FSM states:** INIT, IDLE. Reset (resetn=0) forces INIT with clear pointer = 0.
- **INIT:**
  - Each edge writes 0 to mem[ptr], then ptr increments.
  - The edge that clears word DEPTH-1 moves the FSM to IDLE and sets ptr = 0.
  - we, re and init_req are ignored; rvalid stays 0; rd holds its value.
- **IDLE, init_req=1:** at the edge, go to INIT with ptr = 0. we and re at that same edge are ignored.
- **IDLE, we=1, waddr < DEPTH:** each byte i with wbe[i]=1 is written with wd; other bytes keep their value. A write with wbe=0 is a no-op.
- **IDLE, re=1:**
  - At the edge, rd is loaded with mem[raddr] and rvalid is set to 1.
  - The next edge clears rvalid, unless another read is accepted.
  - When re=0, rd holds its last value.
- **Out of range (waddr or raddr >= DEPTH):**
  - A write is dropped.
  - A read returns rd = 0 with rvalid = 1.
- **Same-edge read and write, raddr == waddr:** write-first. rd returns the merged word: new bytes where wbe=1, old bytes elsewhere.
- **Simultaneous write and read to different addresses:** the two operations are independent.
- **Storage reset:** the memory array has no reset. Only the FSM, ptr, rd and rvalid are reset.
- **Reset asserted mid-INIT or mid-operation:** all control state clears immediately. The clear sequence restarts from word 0 after resetn rises.

## Timing
- **Output values while resetn=0:** rd = 0, rvalid = 0, busy = 1.
- **INIT duration:** exactly DEPTH rising edges after resetn deasserts. busy falls after the DEPTH-th edge.
- **Re-init:** from the init_req edge, busy is high for DEPTH cycles.
- **Read latency:** 1 cycle. Request at edge N gives data and rvalid visible after edge N, valid until edge N+1.
- **Back-to-back reads:** one per cycle. rvalid stays high continuously.
- **Write-to-read visibility:** 0 cycles for the same-edge address match (bypass); otherwise the data is readable from the next edge.
- **busy timing:** busy is a registered function of the FSM state. There is no combinational path from inputs to busy, rd or rvalid.

## Structure
- **Package sram_pkg:** holds the state typedef (enum logic {INIT, IDLE}) and a byte-merge function merge(old, new, be) shared by the write path and the bypass path.
- **Sub-module sram_init_ctrl:** contains the FSM and the clear pointer. Outputs are busy, clr_en and clr_addr.
- **Top level:** instantiates sram_init_ctrl and holds the storage array, the write muxing (clear has priority over user writes) and the read register.

## Test plan
Default parameters (DW=32, DEPTH=8) unless stated.
1. **Reset and clear:** release resetn, hold we=0 -> busy high for 8 cycles then low; reads of addresses 0..7 return 0x00000000, rvalid=1 one cycle after each re.
2. **Full writes and read-back:** write 0xA5A5_0000+k to addresses 0..7 with wbe=0xF, then read 0..7 back-to-back -> rd sequence 0xA5A50000..0xA5A50007, rvalid continuously high for 8 cycles.
3. **Byte enables and bypass:**
   - Write 0x11223344 to addr 3.
   - Then, on the same edge, write 0xAABBCCDD to addr 3 with wbe=0b0101 and read addr 3.
   - Required: rd = 0x11BB33DD, and a later read of addr 3 returns the same value.
4. **Re-init:**
   - In IDLE with non-zero contents, pulse init_req together with we=1 to addr 2.
   - Required: busy high for 8 cycles; the write is dropped; all words read back as 0.
5. **Reset mid-INIT:** assert resetn=0 for 1 ns after the 3rd INIT edge -> rd = 0, rvalid = 0 immediately; after release, busy high for a full 8 cycles.
6. **Non-power-of-2 depth (DEPTH=6):**
   - Write to addr 7 -> no storage changes.
   - Read addr 6 -> rd = 0 with rvalid = 1.
   - INIT lasts 6 cycles.
